elevator_scan_ctrl: RTL and testbench
=====================================

# elevator_scan_ctrl

Parametrised elevator car controller for NUM_FLOORS floors with a registered hall/car call bitmask, SCAN (collective) dispatch, per-floor travel timing and a timed door dwell. Next generation of the team's single-car elevator block: unlimited pending calls instead of a three-deep list, a deterministic cycle-level floor model and an explicit door state. Sits between the button/panel decoder and the floor display/motor-drive logic.

## Interface
- NUM_FLOORS, 5: floors served, ≥2; FW = max(1, $clog2(NUM_FLOORS)).
- TRAVEL_CYCLES, 4: cycles per one-floor hop, ≥1.
- DOOR_CYCLES, 3: cycles door_open stays high per stop, ≥1.
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- call_req  in  NUM_FLOORS  level call per floor; any cycle high sets pending bit.
- estop  in  1  emergency halt (present only with ELEV_ESTOP_EN).
- current_floor  out  FW  registered car position.
- floor_onehot  out  NUM_FLOORS  one-hot decode of current_floor.
- dir_up  out  1  1 = up, 0 = down; holds last value when stopped.
- moving  out  1  high in MOVING.
- door_open  out  1  high in DOOR.
- pending  out  NUM_FLOORS  registered outstanding calls.

## Operation
- Reset (rst_n=0 at posedge): current_floor=0, floor_onehot=1, dir_up=1, moving=0, door_open=0, pending=0, timer=0, state=IDLE. Reset mid-move or mid-door overrides everything.
- Pending: pending <= (pending | call_req) & ~clr, clr = one-hot of floor being serviced; clear wins over a same-cycle set on that floor.
- IDLE: pending[cur] -> DOOR. Else if any pending above/below: keep dir_up if calls remain in that direction, else reverse; -> MOVING. Else stay.
- MOVING: timer loaded TRAVEL_CYCLES-1, decrements each cycle. At timer==0: current_floor ±1; if pending[new floor] -> DOOR; else stay MOVING (reload).
- DOOR: entry clears pending[cur], loads timer DOOR_CYCLES-1; calls for cur while door open are absorbed (bit held clear). At timer==0 -> IDLE.
- Bounds: car never passes 0 or NUM_FLOORS-1; dir reversal happens only in IDLE.
- SCAN: calls ahead in current direction served en route; calls behind wait for reversal.

## Timing
- Call latched edge k (pending visible after k); IDLE reacts edge k+1 (moving=1 after k+1).
- Each hop exactly TRAVEL_CYCLES cycles; floor changes on hop-final edge, same edge as DOOR entry.
- door_open high exactly DOOR_CYCLES cycles; IDLE exactly one cycle before next decision.
- Call at current floor while IDLE: door_open high after edge k+1, no movement.

## Configuration
- ELEV_ESTOP_EN defined: estop port and HALT state exist. estop=1 from any state -> HALT: moving=0, door_open=0, timer frozen, pending still latches. estop=0 -> return to saved state, remaining timer resumes. Reset overrides HALT.
- Undefined: no estop port, no HALT state; behaviour otherwise identical.

## Structure
- elevator_pkg: state enum (IDLE, MOVING, DOOR, HALT), dir encoding constants, FW width function.
- Sub-module elevator_call_reg: pending bitmask set/clear plus above/below any-pending reduction for the FSM.

## Test plan
- Reset: hold rst_n=0 2 cycles -> current_floor=0, dir_up=1, moving=0, door_open=0, pending=0.
- Idle at 0, call_req[3] 1 cycle -> floors 1,2,3 each after 4 cycles, door_open 3 cycles at 3, pending[3] cleared, IDLE.
- Car up 0->4, call_req[2] raised while between 0 and 1 -> stops at 2, then 4; call_req[0] during that -> served only after 4 (reversal).
- Idle at 2, call_req[2] -> door_open next cycle, current_floor stays 2, call_req[2] held during door absorbed.
- rst_n=0 mid-hop 1->2 -> next cycle floor 0, pending 0, moving 0.
- ELEV_ESTOP_EN: estop 5 cycles mid-hop -> moving=0, floor frozen; release -> hop completes with remaining count.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
// ELEV_ESTOP_EN adds the emergency-stop port and HALT state.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width able to index n distinct values, never below one bit.
  function automatic int fw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_scan_ctrl_if.sv
// Call inputs and car status outputs of the elevator controller.
// ELEV_ESTOP_EN adds the estop signal to both modports.
interface elevator_scan_ctrl_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 5
);
  localparam int FW = fw_of(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] call_req;
`ifdef ELEV_ESTOP_EN
  logic                  estop;
`endif
  logic [FW-1:0]         current_floor;
  logic [NUM_FLOORS-1:0] floor_onehot;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
`ifdef ELEV_ESTOP_EN
    output estop,
`endif
    output call_req,
    input  current_floor, floor_onehot, dir_up, moving, door_open, pending
  );

  modport slave (
`ifdef ELEV_ESTOP_EN
    input  estop,
`endif
    input  call_req,
    output current_floor, floor_onehot, dir_up, moving, door_open, pending
  );

endinterface

// File: rtl/elevator_call_reg.sv
// Outstanding-call bitmask with clear-over-set priority, plus
// any-above / any-below reductions relative to the car position.
module elevator_call_reg
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 5,
  parameter int FW         = fw_of(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [NUM_FLOORS-1:0] clr,
  input  logic [FW-1:0]         cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  any_above,
  output logic                  any_below
);

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending | call_req) & ~clr;
  end

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FW'(i) > cur_floor)) any_above = 1'b1;
      if (pending[i] && (FW'(i) < cur_floor)) any_below = 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: hop timing, door dwell, direction.
// ELEV_ESTOP_EN enables the estop input and the HALT freeze state.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 5,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic clk,
  input  logic rst_n,
  elevator_scan_ctrl_if.slave bus
);

  localparam int FW   = fw_of(NUM_FLOORS);
  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = fw_of(TMAX);

  state_t                state;
  logic [TW-1:0]         timer;
  logic [FW-1:0]         cur_floor;
  logic [NUM_FLOORS-1:0] onehot;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] clr;
  logic                  any_above;
  logic                  any_below;
  logic [FW-1:0]         nxt;
  logic                  at_end;
  logic                  go_up;
`ifdef ELEV_ESTOP_EN
  state_t                saved_state;
`endif

  elevator_call_reg #(
    .NUM_FLOORS (NUM_FLOORS),
    .FW         (FW)
  ) u_calls (
    .clk       (clk),
    .rst_n     (rst_n),
    .call_req  (bus.call_req),
    .clr       (clr),
    .cur_floor (cur_floor),
    .pending   (pending),
    .any_above (any_above),
    .any_below (any_below)
  );

  assign nxt    = dir_up ? cur_floor + FW'(1) : cur_floor - FW'(1);
  assign at_end = dir_up ? (nxt == FW'(NUM_FLOORS - 1)) : (nxt == '0);
  // Keep heading while calls remain ahead, otherwise turn around.
  assign go_up  = dir_up ? any_above : !any_below;

  // Clear the serviced floor on the DOOR entry edge and for the whole dwell.
  always_comb begin
    clr = '0;
    case (state)
      IDLE:    if (pending[cur_floor]) clr[cur_floor] = 1'b1;
      MOVING:  if (timer == '0 && pending[nxt]) clr[nxt] = 1'b1;
      DOOR:    clr[cur_floor] = 1'b1;
      default: clr = '0;
    endcase
`ifdef ELEV_ESTOP_EN
    if (bus.estop) clr = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cur_floor <= '0;
      onehot    <= NUM_FLOORS'(1);
      dir_up    <= DIR_UP;
      moving    <= 1'b0;
      door_open <= 1'b0;
`ifdef ELEV_ESTOP_EN
      saved_state <= IDLE;
`endif
    end else
`ifdef ELEV_ESTOP_EN
    if (bus.estop && state != HALT) begin
      saved_state <= state;
      state       <= HALT;
      moving      <= 1'b0;
      door_open   <= 1'b0;
    end else
`endif
    begin
      case (state)
        IDLE: begin
          if (pending[cur_floor]) begin
            state     <= DOOR;
            timer     <= TW'(DOOR_CYCLES - 1);
            door_open <= 1'b1;
          end else if (any_above || any_below) begin
            state  <= MOVING;
            timer  <= TW'(TRAVEL_CYCLES - 1);
            moving <= 1'b1;
            dir_up <= go_up ? DIR_UP : DIR_DOWN;
          end
        end
        MOVING: begin
          if (timer == '0) begin
            cur_floor <= nxt;
            onehot    <= NUM_FLOORS'(1) << nxt;
            if (pending[nxt]) begin
              state     <= DOOR;
              timer     <= TW'(DOOR_CYCLES - 1);
              moving    <= 1'b0;
              door_open <= 1'b1;
            end else if (at_end) begin
              state  <= IDLE;
              moving <= 1'b0;
            end else begin
              timer <= TW'(TRAVEL_CYCLES - 1);
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DOOR: begin
          if (timer == '0) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
`ifdef ELEV_ESTOP_EN
        HALT: begin
          if (!bus.estop) begin
            state     <= saved_state;
            moving    <= (saved_state == MOVING);
            door_open <= (saved_state == DOOR);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.current_floor = cur_floor;
  assign bus.floor_onehot  = onehot;
  assign bus.dir_up        = dir_up;
  assign bus.moving        = moving;
  assign bus.door_open     = door_open;
  assign bus.pending       = pending;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios plus randomized calls
// compared cycle by cycle against an event-rule reference model.
module tb_elevator_scan_ctrl;

  localparam int NF     = 5;
  localparam int TRAVEL = 4;
  localparam int DWELL  = 3;
  localparam int FW     = elevator_pkg::fw_of(NF);

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  elevator_scan_ctrl_if #(.NUM_FLOORS(NF)) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (TRAVEL),
    .DOOR_CYCLES   (DWELL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: floor, heading, outstanding calls, activity and elapsed cycles.
  bit mp[NF];
  int mf;
  bit mdir;
  int mmode;  // 0 idle, 1 travelling, 2 door
  int mel;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.call_req = '0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) mp[i] = 1'b0;
    mf = 0; mdir = 1'b1; mmode = 0; mel = 0;
  endtask

  task automatic model_step(input logic [NF-1:0] req);
    bit np[NF];
    bit above, below;
    for (int i = 0; i < NF; i++) np[i] = mp[i] | req[i];
    if (mmode == 0) begin
      if (mp[mf]) begin
        mmode = 2; mel = 0; np[mf] = 1'b0;
      end else begin
        above = 1'b0; below = 1'b0;
        for (int i = 0; i < NF; i++) if (mp[i]) begin
          if (i > mf) above = 1'b1;
          if (i < mf) below = 1'b1;
        end
        if (above || below) begin
          if (mdir && !above) mdir = 1'b0;
          else if (!mdir && !below) mdir = 1'b1;
          mmode = 1; mel = 0;
        end
      end
    end else if (mmode == 1) begin
      if (mel + 1 == TRAVEL) begin
        mf = mdir ? mf + 1 : mf - 1;
        mel = 0;
        if (mp[mf]) begin
          mmode = 2; np[mf] = 1'b0;
        end
      end else mel++;
    end else begin
      np[mf] = 1'b0;
      if (mel + 1 == DWELL) begin
        mmode = 0; mel = 0;
      end else mel++;
    end
    for (int i = 0; i < NF; i++) mp[i] = np[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.call_req = 5'b10110;
    step(1);
    bus.call_req = '0;
    do_reset();
    checks++;
    if ({bus.current_floor, bus.floor_onehot, bus.dir_up, bus.moving, bus.door_open, bus.pending}
        !== {FW'(0), 5'b00001, 1'b1, 1'b0, 1'b0, 5'b00000})
      $display("FAIL reset: floor=%0d onehot=%b dir=%b mov=%b door=%b pend=%b",
               bus.current_floor, bus.floor_onehot, bus.dir_up, bus.moving, bus.door_open, bus.pending);
    else passed++;
  endtask

  task automatic test_single_call();
    do_reset();
    bus.call_req = 5'b01000;
    step(1);
    bus.call_req = '0;
    checks++;
    if (bus.pending !== 5'b01000 || bus.moving !== 1'b0)
      $display("FAIL latch: pend=%b mov=%b want 01000 0", bus.pending, bus.moving);
    else passed++;
    step(1);
    checks++;
    if (bus.moving !== 1'b1 || bus.dir_up !== 1'b1 || bus.current_floor !== FW'(0))
      $display("FAIL depart: mov=%b dir=%b floor=%0d want 1 1 0", bus.moving, bus.dir_up, bus.current_floor);
    else passed++;
    step(3);
    checks++;
    if (bus.current_floor !== FW'(0))
      $display("FAIL hop_early: floor=%0d want 0", bus.current_floor);
    else passed++;
    for (int f = 1; f <= 3; f++) begin
      step(f == 1 ? 1 : TRAVEL);
      checks++;
      if (bus.current_floor !== FW'(f) || bus.floor_onehot !== NF'(1 << f))
        $display("FAIL hop%0d: floor=%0d onehot=%b want %0d", f, bus.current_floor, bus.floor_onehot, f);
      else passed++;
    end
    checks++;
    if (bus.door_open !== 1'b1 || bus.moving !== 1'b0 || bus.pending !== 5'b00000)
      $display("FAIL arrive3: door=%b mov=%b pend=%b want 1 0 00000", bus.door_open, bus.moving, bus.pending);
    else passed++;
    step(2);
    checks++;
    if (bus.door_open !== 1'b1)
      $display("FAIL dwell: door=%b want 1", bus.door_open);
    else passed++;
    step(1);
    checks++;
    if (bus.door_open !== 1'b0 || bus.moving !== 1'b0 || bus.current_floor !== FW'(3))
      $display("FAIL close: door=%b mov=%b floor=%0d want 0 0 3", bus.door_open, bus.moving, bus.current_floor);
    else passed++;
  endtask

  task automatic test_scan_order();
    int order[$];
    bit prev_door;
    int want[3] = '{2, 4, 0};
    do_reset();
    bus.call_req = 5'b10000;
    step(1);
    bus.call_req = '0;
    step(1);
    bus.call_req = 5'b00101;
    step(1);
    bus.call_req = '0;
    prev_door = 1'b0;
    for (int c = 0; c < 200 && order.size() < 3; c++) begin
      if (bus.door_open && !prev_door) order.push_back(int'(bus.current_floor));
      prev_door = bus.door_open;
      step(1);
    end
    checks++;
    if (order.size() != 3) $display("FAIL scan_count: stops=%0d want 3", order.size());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= order.size() || order[i] != want[i])
        $display("FAIL scan_stop%0d: floor=%0d want %0d", i, (i < order.size()) ? order[i] : -1, want[i]);
      else passed++;
    end
  endtask

  task automatic test_same_floor();
    bit seen;
    do_reset();
    bus.call_req = 5'b00100;
    step(1);
    bus.call_req = '0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.door_open) seen = 1'b1;
      if (seen && !bus.door_open) break;
      step(1);
    end
    checks++;
    if (!seen || bus.door_open !== 1'b0 || bus.current_floor !== FW'(2))
      $display("FAIL reach2: seen=%b door=%b floor=%0d want 1 0 2", seen, bus.door_open, bus.current_floor);
    else passed++;
    bus.call_req = 5'b00100;
    step(1);
    checks++;
    if (bus.pending !== 5'b00100 || bus.door_open !== 1'b0)
      $display("FAIL same_latch: pend=%b door=%b want 00100 0", bus.pending, bus.door_open);
    else passed++;
    for (int c = 0; c < DWELL; c++) begin
      step(1);
      checks++;
      if (bus.door_open !== 1'b1 || bus.pending !== 5'b00000 || bus.moving !== 1'b0 || bus.current_floor !== FW'(2))
        $display("FAIL absorb%0d: door=%b pend=%b mov=%b floor=%0d want 1 00000 0 2",
                 c, bus.door_open, bus.pending, bus.moving, bus.current_floor);
      else passed++;
    end
    step(1);
    bus.call_req = '0;
    checks++;
    if (bus.door_open !== 1'b0 || bus.pending !== 5'b00000)
      $display("FAIL same_close: door=%b pend=%b want 0 00000", bus.door_open, bus.pending);
    else passed++;
  endtask

  task automatic test_reset_mid_hop();
    do_reset();
    bus.call_req = 5'b10000;
    step(1);
    bus.call_req = '0;
    step(1 + TRAVEL + 2);
    checks++;
    if (bus.current_floor !== FW'(1) || bus.moving !== 1'b1)
      $display("FAIL midhop_pre: floor=%0d mov=%b want 1 1", bus.current_floor, bus.moving);
    else passed++;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++;
    if ({bus.current_floor, bus.floor_onehot, bus.moving, bus.door_open, bus.pending, bus.dir_up}
        !== {FW'(0), 5'b00001, 1'b0, 1'b0, 5'b00000, 1'b1})
      $display("FAIL midhop_rst: floor=%0d onehot=%b mov=%b door=%b pend=%b dir=%b",
               bus.current_floor, bus.floor_onehot, bus.moving, bus.door_open, bus.pending, bus.dir_up);
    else passed++;
  endtask

`ifdef ELEV_ESTOP_EN
  task automatic test_estop();
    do_reset();
    bus.call_req = 5'b10000;
    step(1);
    bus.call_req = '0;
    step(3);
    bus.estop = 1'b1;
    step(5);
    bus.estop = 1'b0;
    checks++;
    if (bus.moving !== 1'b0 || bus.current_floor !== FW'(0) || bus.pending !== 5'b10000)
      $display("FAIL halt: mov=%b floor=%0d pend=%b want 0 0 10000", bus.moving, bus.current_floor, bus.pending);
    else passed++;
    step(2);
    checks++;
    if (bus.moving !== 1'b1 || bus.current_floor !== FW'(0))
      $display("FAIL resume: mov=%b floor=%0d want 1 0", bus.moving, bus.current_floor);
    else passed++;
    step(1);
    checks++;
    if (bus.current_floor !== FW'(1))
      $display("FAIL resume_hop: floor=%0d want 1", bus.current_floor);
    else passed++;
  endtask
`endif

  task automatic test_random();
    logic [NF-1:0] req;
    logic [FW+NF+3+NF-1:0] want, got;
    logic [NF-1:0] mpv;
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      req = '0;
      if ($urandom_range(0, 11) == 0) req[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 40) == 0) req = NF'($urandom);
      bus.call_req = req;
      model_step(req);
      step(1);
      for (int i = 0; i < NF; i++) mpv[i] = mp[i];
      want = {FW'(mf), NF'(1 << mf), mdir, (mmode == 1), (mmode == 2), mpv};
      got  = {bus.current_floor, bus.floor_onehot, bus.dir_up, bus.moving, bus.door_open, bus.pending};
      checks++;
      if (got !== want)
        $display("FAIL random c%0d: floor/onehot/dir/mov/door/pend got %b want %b", c, got, want);
      else passed++;
    end
    bus.call_req = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.call_req = '0;
`ifdef ELEV_ESTOP_EN
    bus.estop = 1'b0;
`endif
    step(2);
    test_reset();
    test_single_call();
    test_scan_order();
    test_same_floor();
    test_reset_mid_hop();
`ifdef ELEV_ESTOP_EN
    test_estop();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
